fft_seq_ctrl: RTL and testbench

- Top-level sequencer for the radix-2 DIT FFT core.
- Phase 1: loads N samples into the ping-pong memory at bit-reversed addresses.
- Phase 2: paces the address generator (AGU) one butterfly per cycle and drains the butterfly pipeline before each bank swap.
- Phase 3: streams results out in natural order. Sits between the external stream interface, the AGU, the butterfly unit and the two memory banks.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_issue_pipe.sv | 29 ++
 rtl/fft_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sequencer: size defaults, FSM encoding and the
// bit-reversal helper used to scatter input samples.
package fft_pkg;

    localparam int FFT_MAX_N   = 32;
    localparam int FFT_ADDR_W  = $clog2(FFT_MAX_N);
    localparam int FFT_STAGE_W = 3;
    localparam int FFT_BR_W    = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_SWAP    = 3'd4;
    localparam logic [2:0] ST_UNLOAD  = 3'd5;

    // Mirror the low n bits of v; bits at or above n come out as zero.
    function automatic logic [FFT_BR_W-1:0] fft_bit_rev(input logic [FFT_BR_W-1:0] v,
                                                        input logic [FFT_STAGE_W-1:0] n);
        logic [FFT_BR_W-1:0] r;
        r = '0;
        for (int i = 0; i < FFT_BR_W; i++) begin
            if (i < int'(n)) begin
                r[int'(n) - 1 - i] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_issue_pipe.sv
// Butterfly issue tracker: delays each AGU issue by LATENCY cycles to form the
// write-back strobe, and reports when nothing beyond the current write-back is in flight.
module fft_issue_pipe #(
    parameter int LATENCY = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic issue,
    output logic wr_en,
    output logic empty
);

    localparam logic [LATENCY-1:0] LAST = LATENCY'(1) << (LATENCY - 1);

    logic [LATENCY-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | LATENCY'(issue);
        end
    end

    assign wr_en = sr[LATENCY-1];
    // The output stage is excluded so the sequencer can leave DRAIN on the final write-back.
    assign empty = ~|(sr & ~LAST);

endmodule

// File: rtl/fft_seq_ctrl.sv
// Radix-2 DIT FFT sequencer: bit-reversed load, paced compute stages with drain and bank swap,
// natural-order unload. Defining FFT_SEQ_CTRL_CYCLE_CNT_EN adds the compute_cycles counter port.
module fft_seq_ctrl
    import fft_pkg::*;
#(
    parameter int MAX_N      = FFT_MAX_N,
    parameter int ADDR_W     = $clog2(MAX_N),
    parameter int STAGE_W    = FFT_STAGE_W,
    parameter int BF_LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [STAGE_W-1:0] n_log2,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               load_we,
    output logic [ADDR_W-1:0]  load_addr,
    output logic               agu_rst_n,
    output logic               agu_next_step,
    input  logic               agu_done_stage,
    output logic               bf_wr_en,
    output logic               rd_bank,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  unload_addr,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef FFT_SEQ_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]        compute_cycles
`endif
);

    logic [2:0]         state;
    logic [STAGE_W-1:0] n_reg;
    logic [STAGE_W-1:0] stage;
    logic [ADDR_W-1:0]  cnt;
    logic               first_drain;
    logic               pipe_empty;
    logic [ADDR_W-1:0]  last_samp;
    logic [ADDR_W-1:0]  last_issue;
    logic               start_legal;
    logic               load_last;

    always_comb begin
        last_samp   = ADDR_W'((32'd1 << n_reg) - 32'd1);
        last_issue  = ADDR_W'((32'd1 << (n_reg - STAGE_W'(1))) - 32'd1);
        start_legal = (n_log2 != '0) && (32'(n_log2) <= 32'(ADDR_W));
    end

    assign busy          = (state != ST_IDLE);
    assign agu_rst_n     = busy;
    assign in_ready      = (state == ST_LOAD);
    assign load_we       = in_valid & in_ready;
    assign load_addr     = in_ready ? ADDR_W'(fft_bit_rev(FFT_BR_W'(cnt), FFT_STAGE_W'(n_reg))) : '0;
    assign load_last     = load_we && (cnt == last_samp);
    assign agu_next_step = (state == ST_COMPUTE);
    assign out_valid     = (state == ST_UNLOAD);
    assign unload_addr   = out_valid ? cnt : '0;

    fft_issue_pipe #(
        .LATENCY (BF_LATENCY)
    ) u_issue_pipe (
        .clk   (clk),
        .reset (reset),
        .issue (agu_next_step),
        .wr_en (bf_wr_en),
        .empty (pipe_empty)
    );

    // cnt is shared: load sample index, butterfly issue index, then unload index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            n_reg       <= '0;
            stage       <= '0;
            cnt         <= '0;
            rd_bank     <= 1'b0;
            first_drain <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done        <= 1'b0;
            first_drain <= 1'b0;
            if (agu_done_stage && !first_drain) begin
                err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_legal) begin
                            n_reg <= n_log2;
                            err   <= 1'b0;
                            cnt   <= '0;
                            state <= ST_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_we) begin
                        if (load_last) begin
                            cnt     <= '0;
                            stage   <= '0;
                            rd_bank <= ~rd_bank;
                            state   <= ST_COMPUTE;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (cnt == last_issue) begin
                        cnt         <= '0;
                        first_drain <= 1'b1;
                        state       <= ST_DRAIN;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (first_drain && !agu_done_stage) begin
                        err <= 1'b1;
                    end
                    if (pipe_empty) begin
                        state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    rd_bank <= ~rd_bank;
                    stage   <= stage + STAGE_W'(1);
                    state   <= (stage == n_reg - STAGE_W'(1)) ? ST_UNLOAD : ST_COMPUTE;
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (cnt == last_samp) begin
                            cnt   <= '0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FFT_SEQ_CTRL_CYCLE_CNT_EN
    logic [15:0] cyc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt <= '0;
        end else if (load_last) begin
            cyc_cnt <= '0;
        end else if ((state == ST_COMPUTE || state == ST_DRAIN || state == ST_SWAP) &&
                     (cyc_cnt != 16'hFFFF)) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end

    assign compute_cycles = cyc_cnt;
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl with a behavioural AGU and address scoreboards.
module tb_fft_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] n_log2 = 3'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       load_we;
    logic [4:0] load_addr;
    logic       agu_rst_n;
    logic       agu_next_step;
    logic       agu_done_stage = 1'b0;
    logic       bf_wr_en;
    logic       rd_bank;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [4:0] unload_addr;
    logic       busy;
    logic       done;
    logic       err;
`ifdef FFT_SEQ_CTRL_CYCLE_CNT_EN
    logic [15:0] compute_cycles;
`endif

    fft_seq_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .n_log2         (n_log2),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .load_we        (load_we),
        .load_addr      (load_addr),
        .agu_rst_n      (agu_rst_n),
        .agu_next_step  (agu_next_step),
        .agu_done_stage (agu_done_stage),
        .bf_wr_en       (bf_wr_en),
        .rd_bank        (rd_bank),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .unload_addr    (unload_addr),
        .busy           (busy),
        .done           (done),
        .err            (err)
`ifdef FFT_SEQ_CTRL_CYCLE_CNT_EN
        ,
        .compute_cycles (compute_cycles)
`endif
    );

    always #5 clk = ~clk;

    localparam int LAT = 3;

    int checks = 0;
    int errors = 0;

    // AGU model: one stage is N/2 steps; the stage-done pulse lands on the first DRAIN cycle.
    int cur_n = 3;
    int agu_suppress = -1;
    int agu_cnt = 0;
    int agu_stg = 0;

    always @(posedge clk) begin
        if (reset || !agu_rst_n) begin
            agu_cnt        <= 0;
            agu_stg        <= 0;
            agu_done_stage <= 1'b0;
        end else begin
            agu_done_stage <= 1'b0;
            if (agu_next_step) begin
                if (agu_cnt == (1 << cur_n) / 2 - 1) begin
                    agu_cnt        <= 0;
                    agu_stg        <= agu_stg + 1;
                    agu_done_stage <= (agu_stg != agu_suppress);
                end else begin
                    agu_cnt <= agu_cnt + 1;
                end
            end
        end
    end

    int load_q[$];
    int unload_q[$];
    int ld_cnt, ul_cnt, step_cnt, bf_cnt, comp_cyc, tog_cnt, done_cnt;
    int prev_addr;
    logic prev_stall;
    logic prev_bank;
    logic done_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bitrev(input int v, input int n);
        int r = 0;
        for (int i = 0; i < n; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic mon_clear();
        ld_cnt = 0; ul_cnt = 0; step_cnt = 0; bf_cnt = 0; comp_cyc = 0;
        tog_cnt = 0; done_cnt = 0; done_seen = 1'b0; prev_stall = 1'b0;
        prev_bank = rd_bank;
    endtask

    task automatic mon_sample();
        if (!reset) begin
            if (load_we) begin
                ld_cnt++;
                if (load_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL load_extra got addr %0d expected no write", load_addr);
                end else begin
                    chk("load_addr", int'(load_addr), load_q.pop_front());
                end
            end
            if (prev_stall && out_valid) chk("unload_hold", int'(unload_addr), prev_addr);
            if (out_valid && out_ready) begin
                ul_cnt++;
                if (unload_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unload_extra got addr %0d expected no transfer", unload_addr);
                end else begin
                    chk("unload_addr", int'(unload_addr), unload_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = int'(unload_addr);
            if (agu_next_step) step_cnt++;
            if (bf_wr_en) bf_cnt++;
            if (busy && !in_ready && !out_valid) comp_cyc++;
            if (rd_bank != prev_bank) tog_cnt++;
            prev_bank = rd_bank;
            if (done) begin
                done_cnt++;
                done_seen = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mon_sample();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int n;
        int stall;
        int suppress;
        int exp_busy;
        int exp_err_start;
        int exp_err_end;
    } vec_t;

    vec_t tbl[9];
    logic [3:0] pat = 4'b1001;

    task automatic prep(input int n);
        load_q.delete();
        unload_q.delete();
        for (int i = 0; i < (1 << n); i++) begin
            load_q.push_back(bitrev(i, n));
            unload_q.push_back(i);
        end
        mon_clear();
    endtask

    task automatic run_entry(input vec_t v);
        int nn;
        int k;
        nn = 1 << v.n;
        cur_n = v.n;
        agu_suppress = v.suppress;
        if (v.exp_busy != 0) prep(v.n);
        else begin
            load_q.delete();
            unload_q.delete();
            mon_clear();
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        n_log2 = 3'(v.n);
        cycle();
        start = 1'b0;
        chk("start_err", int'(err), v.exp_err_start);
        chk("start_busy", int'(busy), v.exp_busy);
        if (v.exp_busy != 0) begin
            chk("load_ready", int'(in_ready), 1);
            k = 0;
            for (int c = 0; c < 4000 && !done_seen; c++) begin
                out_ready = (v.stall != 0 && out_valid) ? pat[k % 4] : 1'b1;
                if (out_valid) k++;
                cycle();
            end
            chk("done_seen", int'(done_seen), 1);
            out_ready = 1'b1;
            cycle();
            chk("done_pulses", done_cnt, 1);
            chk("idle_after_done", int'(busy), 0);
            chk("load_count", ld_cnt, nn);
            chk("unload_count", ul_cnt, nn);
            chk("load_left", load_q.size(), 0);
            chk("unload_left", unload_q.size(), 0);
            chk("agu_steps", step_cnt, v.n * nn / 2);
            chk("bf_writes", bf_cnt, v.n * nn / 2);
            chk("compute_cycles_seen", comp_cyc, v.n * (nn / 2 + LAT + 1));
            chk("bank_toggles", tog_cnt, v.n + 1);
            chk("end_err", int'(err), v.exp_err_end);
`ifdef FFT_SEQ_CTRL_CYCLE_CNT_EN
            chk("compute_cycles", int'(compute_cycles), v.n * (nn / 2 + LAT + 1));
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        //          n  stall sup busy err0 errEnd
        tbl[0] = '{0, 0, -1, 0, 1, 1};
        tbl[1] = '{3, 0, -1, 1, 0, 0};
        tbl[2] = '{6, 0, -1, 0, 1, 1};
        tbl[3] = '{3, 1, -1, 1, 0, 0};
        tbl[4] = '{3, 0,  1, 1, 0, 1};
        tbl[5] = '{1, 0, -1, 1, 0, 0};
        tbl[6] = '{5, 0, -1, 1, 0, 0};
        tbl[7] = '{2, 0, -1, 1, 0, 0};
        tbl[8] = '{7, 0, -1, 0, 1, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_agu_rst_n", int'(agu_rst_n), 0);
        chk("rst_rd_bank", int'(rd_bank), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b0;
        cycle();

        for (int i = 0; i < 9; i++) run_entry(tbl[i]);

        // Abort in the second compute stage; stage-1 done is withheld so err is set first.
        cur_n = 3;
        agu_suppress = 0;
        prep(3);
        start = 1'b1;
        n_log2 = 3'd3;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 200 && step_cnt < 6; c++) cycle();
        chk("abort_steps", step_cnt, 6);
        chk("abort_in_compute", int'(agu_next_step), 1);
        chk("abort_bank_pre", int'(rd_bank), 1);
        chk("abort_err_pre", int'(err), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_load_we", int'(load_we), 0);
        chk("abort_next_step", int'(agu_next_step), 0);
        chk("abort_bf_wr_en", int'(bf_wr_en), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_rd_bank", int'(rd_bank), 0);
        chk("abort_agu_rst_n", int'(agu_rst_n), 0);
        chk("abort_load_addr", int'(load_addr), 0);
        chk("abort_unload_addr", int'(unload_addr), 0);
        reset = 1'b0;
        cycle();

        run_entry('{3, 0, -1, 1, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
